// File: rtl/jt12_wr_queue.sv
// Posted-write buffer in front of jt12_mmr: queues host writes in a FIFO and
// replays them one at a time through the register map's busy handshake.
module jt12_wr_queue #(
    parameter int AW  = 4,
    parameter int GAP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_wr,
    input  logic [1:0]  host_addr,
    input  logic [7:0]  host_din,
    input  logic        ovf_clr,
    output logic        mmr_write,
    output logic [1:0]  mmr_addr,
    output logic [7:0]  mmr_din,
    input  logic        mmr_busy,
    output logic        status_busy,
    output logic [AW:0] level,
    output logic        overflow
);
    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, GAPW} state_t;

    state_t        state_q, state_d;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [3:0]    gap_q, gap_d;
    logic          pop, push, drop;

    // An acceptance frees a slot in the same cycle, so a full queue can still take a write.
    assign pop  = (state_q == ISSUE) && !mmr_busy;
    assign push = host_wr && ((level_q != FULL) || pop);
    assign drop = host_wr && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host_addr, host_din};
        end
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + ONE;
        end else if (pop && !push) begin
            level_d = level_q - ONE;
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        din_d   = din_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    {addr_d, din_d} = mem_q[rd_ptr_q];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                if (!mmr_busy) begin
                    state_d = SETTLE;
                end
            end
            // The register map only raises busy one cycle after it accepts a write.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (!mmr_busy) begin
                    if (GAP > 0) begin
                        state_d = GAPW;
                        gap_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAPW: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            gap_q    <= gap_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign mmr_write   = (state_q == ISSUE);
    assign mmr_addr    = addr_q;
    assign mmr_din     = din_q;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign status_busy = (level_q != '0) || mmr_busy || (state_q != IDLE);

endmodule

// File: tb/tb_jt12_wr_queue.sv
// Bench for jt12_wr_queue: an ordered queue model plus a behavioural busy
// model of jt12_mmr; two instances cover GAP=0 and GAP=3.
module tb_jt12_wr_queue;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       host_wr;
    logic [1:0] host_addr;
    logic [7:0] host_din;
    logic       ovf_clr;
    logic       busy;
    logic       sel;

    logic w0, w1, sb0, sb1, of0, of1;
    logic [1:0] a0, a1;
    logic [7:0] d0, d1;
    logic [AW:0] lv0, lv1;

    jt12_wr_queue #(.AW(AW), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .host_wr(host_wr && !sel), .host_addr(host_addr),
        .host_din(host_din), .ovf_clr(ovf_clr && !sel), .mmr_write(w0), .mmr_addr(a0),
        .mmr_din(d0), .mmr_busy(busy), .status_busy(sb0), .level(lv0), .overflow(of0)
    );

    jt12_wr_queue #(.AW(AW), .GAP(3)) dut1 (
        .clk(clk), .rst(rst), .host_wr(host_wr && sel), .host_addr(host_addr),
        .host_din(host_din), .ovf_clr(ovf_clr && sel), .mmr_write(w1), .mmr_addr(a1),
        .mmr_din(d1), .mmr_busy(busy), .status_busy(sb1), .level(lv1), .overflow(of1)
    );

    always #5 clk = ~clk;

    logic        o_wr, o_sb, o_ovf;
    logic [1:0]  o_addr;
    logic [7:0]  o_din;
    logic [AW:0] o_level;
    assign o_wr    = sel ? w1  : w0;
    assign o_sb    = sel ? sb1 : sb0;
    assign o_ovf   = sel ? of1 : of0;
    assign o_addr  = sel ? a1  : a0;
    assign o_din   = sel ? d1  : d0;
    assign o_level = sel ? lv1 : lv0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [9:0] exp_q[$];
    logic       m_ovf;
    int         busy_cnt, busy_len, gap_cur, cyc, last_acc, n_acc;
    bit         force_busy, spacing_en;
    logic       prev_wr, prev_busy, prev_rst;
    logic [9:0] prev_ad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic void upd_busy();
        busy = force_busy || (busy_cnt > 0);
    endfunction

    // Cycles between consecutive acceptances when the next entry is already queued:
    // busy window (at least the SETTLE cycle), the low WAIT cycle, IDLE, ISSUE, plus the gap.
    function automatic int exp_spacing();
        return ((busy_len > 1) ? busy_len : 1) + 3 + gap_cur;
    endfunction

    task automatic step();
        bit acc, push, drop;
        acc  = !rst && (o_wr === 1'b1) && !busy;
        push = !rst && host_wr && ((exp_q.size() < DEPTH) || acc);
        drop = !rst && host_wr && !push;
        prev_wr   = o_wr;
        prev_busy = busy;
        prev_rst  = rst;
        prev_ad   = {o_addr, o_din};
        if (acc) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                chk("acc_queue_size", 32'(exp_q.size()), 1);
            end else begin
                chk("acc_order", {o_addr, o_din}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (spacing_en && last_acc >= 0) chk("strobe_spacing", cyc - last_acc, exp_spacing());
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rst) begin
            exp_q.delete();
            m_ovf    = 1'b0;
            busy_cnt = 0;
        end else begin
            if (push) exp_q.push_back({host_addr, host_din});
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (acc) busy_cnt = busy_len;
            else if (busy_cnt > 0) busy_cnt--;
        end
        upd_busy();
        host_wr = 1'b0;
        ovf_clr = 1'b0;
        chk("level", o_level, exp_q.size());
        chk("overflow", o_ovf, m_ovf);
        if (acc) chk("pulse_one_cycle", o_wr, 0);
        if (prev_wr === 1'b1 && prev_busy && !prev_rst) begin
            chk("hold_write", o_wr, 1);
            chk("hold_addr_din", {o_addr, o_din}, prev_ad);
        end
        if (o_wr === 1'b1) chk("write_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0 || busy) chk("status_busy_on", o_sb, 1);
    endtask

    task automatic push_wr(input logic [1:0] a, input logic [7:0] d);
        host_wr   = 1'b1;
        host_addr = a;
        host_din  = d;
        step();
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() > 0 || busy) && k < 800) begin
            step();
            k++;
        end
        chk("drain_complete", exp_q.size(), 0);
        repeat (8) step();
        chk("drain_level", o_level, 0);
        chk("drain_idle", o_sb, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; sel = 1'b0; host_wr = 1'b0; host_addr = '0; host_din = '0; ovf_clr = 1'b0;
        busy_cnt = 0; busy_len = 3; gap_cur = 0; cyc = 0; last_acc = -1; n_acc = 0;
        force_busy = 1'b0; spacing_en = 1'b0; m_ovf = 1'b0;
        prev_wr = 1'b0; prev_busy = 1'b0; prev_rst = 1'b1; prev_ad = '0;
        upd_busy();
        step();
        step();
        rst = 1'b0;
        chk("rst_level0", lv0, 0);
        chk("rst_level1", lv1, 0);
        chk("rst_ovf0", of0, 0);
        chk("rst_ovf1", of1, 0);
        chk("rst_write0", w0, 0);
        chk("rst_write1", w1, 0);
        chk("rst_addr_din0", {a0, d0}, 0);
        chk("rst_status0", sb0, 0);
        chk("rst_status1", sb1, 0);

        // Single address/data pair, busy high for 3 cycles after each acceptance
        spacing_en = 1'b1; last_acc = -1; base = n_acc;
        push_wr(2'd0, 8'h28);
        chk("pair_no_bypass", o_wr, 0);
        push_wr(2'd1, 8'hF0);
        chk("pair_first_strobe", o_wr, 1);
        chk("pair_first_addr_din", {o_addr, o_din}, {2'd0, 8'h28});
        drain();
        chk("pair_count", n_acc - base, 2);

        // Burst fill to 16 while the register map is busy, then replay
        force_busy = 1'b1; upd_busy();
        for (int i = 0; i < 16; i++) push_wr(2'(i), 8'(i));
        chk("burst_level16", o_level, 16);
        chk("burst_no_ovf", o_ovf, 0);
        force_busy = 1'b0; upd_busy(); last_acc = -1; base = n_acc;
        drain();
        chk("burst_count", n_acc - base, 16);

        // Overflow: 17th write dropped, sticky until cleared
        force_busy = 1'b1; upd_busy();
        for (int i = 0; i < 17; i++) push_wr(2'($urandom), 8'($urandom));
        chk("ovf_set", o_ovf, 1);
        chk("ovf_level", o_level, 16);
        ovf_clr = 1'b1;
        step();
        chk("ovf_cleared", o_ovf, 0);
        force_busy = 1'b0; upd_busy(); last_acc = -1; base = n_acc;
        drain();
        chk("ovf_count", n_acc - base, 16);

        // Write landing on a full queue in the same cycle as an acceptance
        force_busy = 1'b1; upd_busy();
        for (int i = 0; i < 16; i++) push_wr(2'($urandom), 8'($urandom));
        force_busy = 1'b0; upd_busy(); last_acc = -1; base = n_acc;
        push_wr(2'd3, 8'hA5);
        chk("pushpop_level", o_level, 16);
        chk("pushpop_no_ovf", o_ovf, 0);
        drain();
        chk("pushpop_count", n_acc - base, 17);

        // GAP=3 instance
        sel = 1'b1; gap_cur = 3; busy_len = 1; last_acc = -1; base = n_acc;
        push_wr(2'd0, 8'h2B);
        push_wr(2'd1, 8'h80);
        drain();
        chk("gap_count", n_acc - base, 2);

        // Reset while a strobe is being held by busy
        sel = 1'b0; gap_cur = 0; busy_len = 3;
        force_busy = 1'b1; upd_busy();
        push_wr(2'd2, 8'h55);
        step();
        chk("rst_mid_issue_write", o_wr, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_write", o_wr, 0);
        chk("rst_mid_level", o_level, 0);
        chk("rst_mid_status", o_sb, busy);
        force_busy = 1'b0; upd_busy(); base = n_acc;
        repeat (20) step();
        chk("rst_mid_no_strobes", n_acc - base, 0);
        chk("rst_mid_idle", o_sb, 0);

        // Random traffic with random busy lengths and busy stalls
        spacing_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            busy_len = int'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) force_busy = !force_busy;
            upd_busy();
            host_wr   = ($urandom_range(0, 99) < 45);
            host_addr = 2'($urandom);
            host_din  = 8'($urandom);
            ovf_clr   = ($urandom_range(0, 29) == 0);
            step();
        end
        force_busy = 1'b0; upd_busy();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
